// File: rtl/trap_ctrl_if.sv
// Commit-stage <-> trap sequencer bundle: request/CSR inputs, flush and
// redirect handshakes, and the CSR write-back port.
interface trap_ctrl_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] pc;
    logic            except;
    logic            intr;
    logic [5:0]      cause;
    logic [XLEN-1:0] tval;
    logic            mret;
    logic            sret;
    logic [1:0]      priv;
    logic [XLEN-1:0] medeleg;
    logic [XLEN-1:0] mideleg;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] stvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] sepc;
    logic [1:0]      mpp;
    logic            spp;
    logic            busy;
    logic            flush;
    logic            flush_ack;
    logic            csr_we;
    logic            csr_s;
    logic [XLEN-1:0] csr_epc;
    logic [XLEN-1:0] csr_cause;
    logic [XLEN-1:0] csr_tval;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      priv_out;
    logic            xret_commit;

    modport master (
        output pc, except, intr, cause, tval, mret, sret, priv,
        output medeleg, mideleg, mtvec, stvec, mepc, sepc, mpp, spp,
        output flush_ack, redirect_ready,
        input  busy, flush, csr_we, csr_s, csr_epc, csr_cause, csr_tval,
        input  redirect_valid, redirect_pc, priv_out, xret_commit
    );

    modport slave (
        input  pc, except, intr, cause, tval, mret, sret, priv,
        input  medeleg, mideleg, mtvec, stvec, mepc, sepc, mpp, spp,
        input  flush_ack, redirect_ready,
        output busy, flush, csr_we, csr_s, csr_epc, csr_cause, csr_tval,
        output redirect_valid, redirect_pc, priv_out, xret_commit
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap-entry / xRET sequencer: decides target privilege and redirect PC,
// then walks flush -> CSR write -> redirect.
module trap_ctrl #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, WRITE, REDIRECT} state_t;

    state_t          state_q, state_d;
    logic            is_xret_q, is_xret_d;
    logic            intr_q, intr_d;
    logic            csr_s_q, csr_s_d;
    logic [5:0]      cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [1:0]      priv_new_q, priv_new_d;
    logic [1:0]      priv_q, priv_d;

    logic            any_req, sel_intr, sel_mret, sel_sret, illegal_sret;
    logic            take_trap, deleg;
    logic [5:0]      trap_cause;
    logic [XLEN-1:0] tvec, tvec_base, vec_off, trap_target;

    // Request decode: except > intr > mret > sret; sret from U-mode becomes
    // an illegal-instruction exception (cause 2, tval 0).
    always_comb begin
        any_req      = bus.except | bus.intr | bus.mret | bus.sret;
        sel_intr     = !bus.except && bus.intr;
        sel_mret     = !bus.except && !bus.intr && bus.mret;
        sel_sret     = !bus.except && !bus.intr && !bus.mret && bus.sret;
        illegal_sret = sel_sret && (bus.priv == 2'b00);
        take_trap    = bus.except | sel_intr | illegal_sret;
        trap_cause   = illegal_sret ? 6'd2 : bus.cause;
        deleg        = (bus.priv != 2'b11) &&
                       (sel_intr ? bus.mideleg[trap_cause] : bus.medeleg[trap_cause]);
        tvec         = deleg ? bus.stvec : bus.mtvec;
        tvec_base    = {tvec[XLEN-1:2], 2'b00};
        vec_off      = {{(XLEN-8){1'b0}}, trap_cause, 2'b00};
        trap_target  = ((tvec[1:0] == 2'b01) && sel_intr) ? tvec_base + vec_off : tvec_base;
    end

    always_comb begin
        state_d    = state_q;
        is_xret_d  = is_xret_q;
        intr_d     = intr_q;
        csr_s_d    = csr_s_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        tval_d     = tval_q;
        target_d   = target_q;
        priv_new_d = priv_new_q;
        priv_d     = priv_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = FLUSH;
                    epc_d     = bus.pc;
                    cause_d   = trap_cause;
                    is_xret_d = !take_trap;
                    intr_d    = sel_intr;
                    if (take_trap) begin
                        tval_d     = illegal_sret ? '0 : bus.tval;
                        csr_s_d    = deleg;
                        target_d   = trap_target;
                        priv_new_d = deleg ? 2'b01 : 2'b11;
                    end else begin
                        tval_d     = bus.tval;
                        csr_s_d    = 1'b0;
                        target_d   = sel_mret ? bus.mepc : bus.sepc;
                        priv_new_d = sel_mret ? bus.mpp : {1'b0, bus.spp};
                    end
                end
            end
            FLUSH: begin
                if (bus.flush_ack) state_d = is_xret_q ? REDIRECT : WRITE;
            end
            WRITE: state_d = REDIRECT;
            REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d = IDLE;
                    priv_d  = priv_new_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            is_xret_q  <= 1'b0;
            intr_q     <= 1'b0;
            csr_s_q    <= 1'b0;
            cause_q    <= '0;
            epc_q      <= '0;
            tval_q     <= '0;
            target_q   <= '0;
            priv_new_q <= 2'b11;
            priv_q     <= 2'b11;
        end else begin
            state_q    <= state_d;
            is_xret_q  <= is_xret_d;
            intr_q     <= intr_d;
            csr_s_q    <= csr_s_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            tval_q     <= tval_d;
            target_q   <= target_d;
            priv_new_q <= priv_new_d;
            priv_q     <= priv_d;
        end
    end

    // csr_we is gated by rst so a reset landing on WRITE never commits the CSRs.
    assign bus.busy           = (state_q != IDLE);
    assign bus.flush          = (state_q == FLUSH);
    assign bus.csr_we         = (state_q == WRITE) && !rst;
    assign bus.csr_s          = csr_s_q;
    assign bus.csr_epc        = epc_q;
    assign bus.csr_cause      = {intr_q, {(XLEN-7){1'b0}}, cause_q};
    assign bus.csr_tval       = tval_q;
    assign bus.redirect_valid = (state_q == REDIRECT);
    assign bus.redirect_pc    = target_q;
    assign bus.priv_out       = priv_q;
    assign bus.xret_commit    = (state_q == REDIRECT) && bus.redirect_ready && is_xret_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected results are queued at request time
// and checked when the sequencer writes CSRs and redirects.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    typedef struct {
        bit          trap;
        logic        csr_s;
        logic [63:0] epc;
        logic [63:0] cause;
        logic [63:0] tval;
        logic [63:0] rpc;
        logic [1:0]  priv;
    } exp_t;
    exp_t sb[$];

    trap_ctrl_if #(.XLEN(64)) bus ();

    trap_ctrl #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        bus.except = 1'b0;
        bus.intr   = 1'b0;
        bus.mret   = 1'b0;
        bus.sret   = 1'b0;
    endtask

    // Drive one request (caller is at a negedge) and queue its expected outcome.
    task automatic req(input logic e, input logic i, input logic m, input logic s,
                       input logic [1:0] pv, input logic [5:0] c,
                       input logic [63:0] p, input logic [63:0] t, input exp_t ex);
        bus.except = e;
        bus.intr   = i;
        bus.mret   = m;
        bus.sret   = s;
        bus.priv   = pv;
        bus.cause  = c;
        bus.pc     = p;
        bus.tval   = t;
        sb.push_back(ex);
    endtask

    // Follow one sequence to completion; ack_dly/rdy_dly = cycles flush/redirect_valid stay up.
    task automatic run_txn(input string nm, input int ack_dly, input int rdy_dly, input bit inject);
        int   flush_cnt = 0;
        int   we_cnt    = 0;
        int   rv_cnt    = 0;
        int   xc_cnt    = 0;
        bit   done      = 0;
        exp_t ex;
        ex = sb.pop_front();
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                clear_req();
                bus.pc   = 64'hDEAD_BEEF_0000_0000;
                bus.tval = 64'hBAD0_BAD0;
                chk({nm, " busy@T+1"}, 64'(bus.busy), 64'd1);
                chk({nm, " flush@T+1"}, 64'(bus.flush), 64'd1);
            end
            if (inject && cyc == 2) begin
                bus.except = 1'b1;
                bus.cause  = 6'd1;
            end
            if (inject && cyc == 3) clear_req();
            if (bus.flush) flush_cnt++;
            if (bus.csr_we) begin
                we_cnt++;
                chk({nm, " csr_s"},     64'(bus.csr_s), 64'(ex.csr_s));
                chk({nm, " csr_epc"},   bus.csr_epc,    ex.epc);
                chk({nm, " csr_cause"}, bus.csr_cause,  ex.cause);
                chk({nm, " csr_tval"},  bus.csr_tval,   ex.tval);
            end
            if (bus.redirect_valid) begin
                rv_cnt++;
                chk({nm, " redirect_pc"}, bus.redirect_pc, ex.rpc);
            end
            bus.flush_ack      = bus.flush && (flush_cnt >= ack_dly);
            bus.redirect_ready = bus.redirect_valid && (rv_cnt >= rdy_dly);
            #1;
            if (bus.xret_commit) xc_cnt++;
            if (bus.redirect_ready) done = 1;
        end
        chk({nm, " completed"}, 64'(done), 64'd1);
        @(negedge clk);
        bus.flush_ack      = 1'b0;
        bus.redirect_ready = 1'b0;
        chk({nm, " busy after"},  64'(bus.busy),     64'd0);
        chk({nm, " priv_out"},    64'(bus.priv_out), 64'(ex.priv));
        chk({nm, " flush cycles"}, 64'(flush_cnt),   64'(ack_dly));
        chk({nm, " valid cycles"}, 64'(rv_cnt),      64'(rdy_dly));
        chk({nm, " csr_we count"}, 64'(we_cnt),      ex.trap ? 64'd1 : 64'd0);
        chk({nm, " xret_commit count"}, 64'(xc_cnt), ex.trap ? 64'd0 : 64'd1);
        $display("txn %s: flush=%0d we=%0d valid=%0d xret=%0d pc=%h priv=%0d",
                 nm, flush_cnt, we_cnt, rv_cnt, xc_cnt, ex.rpc, bus.priv_out);
    endtask

    initial begin
        int seen_we;
        int late;
        rst = 1'b1;
        clear_req();
        bus.pc = '0; bus.tval = '0; bus.cause = '0; bus.priv = 2'b11;
        bus.medeleg = '0; bus.mideleg = '0;
        bus.mtvec = 64'h9000_0000; bus.stvec = '0;
        bus.mepc = '0; bus.sepc = '0; bus.mpp = 2'b11; bus.spp = 1'b0;
        bus.flush_ack = 1'b0; bus.redirect_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy",     64'(bus.busy),           64'd0);
        chk("rst flush",    64'(bus.flush),          64'd0);
        chk("rst csr_we",   64'(bus.csr_we),         64'd0);
        chk("rst rvalid",   64'(bus.redirect_valid), 64'd0);
        chk("rst xret",     64'(bus.xret_commit),    64'd0);
        chk("rst priv_out", 64'(bus.priv_out),       64'd3);
        chk("rst rpc",      bus.redirect_pc,         64'd0);
        chk("rst epc",      bus.csr_epc,             64'd0);
        rst = 1'b0;
        @(negedge clk);

        // U-mode ecall delegated to S
        bus.medeleg = 64'h100; bus.stvec = 64'h8000_1000;
        req(1, 0, 0, 0, 2'b00, 6'd8, 64'h4000_0100, 64'h55,
            '{1, 1'b1, 64'h4000_0100, 64'd8, 64'h55, 64'h8000_1000, 2'b01});
        run_txn("u_deleg", 1, 1, 0);

        // Same cause from M-mode is never delegated
        req(1, 0, 0, 0, 2'b11, 6'd8, 64'h4000_0200, 64'h66,
            '{1, 1'b0, 64'h4000_0200, 64'd8, 64'h66, 64'h9000_0000, 2'b11});
        run_txn("m_nodeleg", 1, 1, 0);

        // Vectored mtvec: interrupt offsets, exception does not
        bus.mtvec = 64'h8000_0001;
        req(0, 1, 0, 0, 2'b11, 6'd7, 64'h4000_0300, 64'h0,
            '{1, 1'b0, 64'h4000_0300, 64'h8000_0000_0000_0007, 64'h0, 64'h8000_001C, 2'b11});
        run_txn("vec_intr", 1, 1, 0);
        req(1, 0, 0, 0, 2'b11, 6'd7, 64'h4000_0400, 64'h77,
            '{1, 1'b0, 64'h4000_0400, 64'd7, 64'h77, 64'h8000_0000, 2'b11});
        run_txn("vec_exc", 1, 1, 0);

        // except + mret together: trap only
        bus.mtvec = 64'h8000_0100;
        bus.mret  = 1'b1;
        req(1, 0, 1, 0, 2'b11, 6'd3, 64'h4000_0500, 64'h88,
            '{1, 1'b0, 64'h4000_0500, 64'd3, 64'h88, 64'h8000_0100, 2'b11});
        run_txn("exc_mret", 1, 1, 0);

        // mret to U-mode
        bus.mpp = 2'b00; bus.mepc = 64'h1234;
        req(0, 0, 1, 0, 2'b11, 6'd0, 64'h4000_0600, 64'h0,
            '{0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h1234, 2'b00});
        run_txn("mret", 1, 1, 0);

        // sret from U-mode is illegal -> cause 2, tval 0, taken in M
        bus.medeleg = '0;
        req(0, 0, 0, 1, 2'b00, 6'd9, 64'h4000_0700, 64'h99,
            '{1, 1'b0, 64'h4000_0700, 64'd2, 64'h0, 64'h8000_0100, 2'b11});
        run_txn("sret_illegal", 1, 1, 0);

        // legal sret from S to S
        bus.spp = 1'b1; bus.sepc = 64'h2000;
        req(0, 0, 0, 1, 2'b01, 6'd0, 64'h4000_0800, 64'h0,
            '{0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h2000, 2'b01});
        run_txn("sret", 1, 1, 0);

        // Slow acks, delegated vectored interrupt, request injected mid-sequence
        bus.mideleg = 64'h20; bus.stvec = 64'h8000_2001;
        req(0, 1, 0, 0, 2'b01, 6'd5, 64'h4000_0900, 64'hAA,
            '{1, 1'b1, 64'h4000_0900, 64'h8000_0000_0000_0005, 64'hAA, 64'h8000_2014, 2'b01});
        run_txn("slow_acks", 5, 3, 1);
        chk("no ghost request", 64'(bus.busy), 64'd0);

        // Reset landing on WRITE
        req(1, 0, 0, 0, 2'b11, 6'd4, 64'h4000_0A00, 64'hBB,
            '{1, 1'b0, 64'h4000_0A00, 64'd4, 64'hBB, 64'h8000_0100, 2'b11});
        void'(sb.pop_front());
        seen_we = 0;
        for (int cyc = 0; cyc < 10 && seen_we == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) clear_req();
            bus.flush_ack = bus.flush;
            if (bus.csr_we) seen_we = 1;
        end
        chk("rst_write reached WRITE", 64'(seen_we), 64'd1);
        rst = 1'b1;
        bus.flush_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_write busy",     64'(bus.busy),           64'd0);
        chk("rst_write rvalid",   64'(bus.redirect_valid), 64'd0);
        chk("rst_write priv_out", 64'(bus.priv_out),       64'd3);
        chk("rst_write epc",      bus.csr_epc,             64'd0);
        late = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.csr_we || bus.redirect_valid || bus.flush) late++;
        end
        chk("rst_write no further activity", 64'(late), 64'd0);
        $display("txn rst_write: reset during WRITE, activity after reset=%0d", late);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
